// File: rtl/vga_timing_pkg.sv
// Shared VGA mode tables and sizing helper for the raster timing generator.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned h_visible;
    int unsigned h_fporch_end;
    int unsigned h_sync_end;
    int unsigned h_bporch_end;
    int unsigned v_visible;
    int unsigned v_fporch_end;
    int unsigned v_sync_end;
    int unsigned v_bporch_end;
  } vga_mode_t;

  localparam vga_mode_t XGA_1024x768 = '{1024, 1048, 1184, 1344, 768, 771, 777, 806};
  localparam vga_mode_t SVGA_800x600 = '{800, 840, 968, 1056, 600, 601, 605, 628};
  localparam vga_mode_t TEST_8x4     = '{8, 10, 12, 14, 4, 5, 6, 8};

  // Bits needed to hold indices 0..total-1.
  function automatic int unsigned cnt_width(input int unsigned total);
    return (total <= 1) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipe with an async reset value; DEPTH=0 is a plain wire.
module vga_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_rst_val,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = ^{i_clk, i_rst, i_rst_val};
      assign o_dat    = i_dat;
    end else begin : g_pipe
      logic [W-1:0] r_stage [DEPTH];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int k = 0; k < DEPTH; k++) r_stage[k] <= i_rst_val;
        end else begin
          r_stage[0] <= i_dat;
          for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
        end
      end

      assign o_dat = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: counters, syncs, data enable, line/frame strobes and line prefetch.
// Outputs are registered from next-state values so every output is coherent with hcnt/vcnt.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int h_visible    = XGA_1024x768.h_visible,
  parameter int h_fporch_end = XGA_1024x768.h_fporch_end,
  parameter int h_sync_end   = XGA_1024x768.h_sync_end,
  parameter int h_bporch_end = XGA_1024x768.h_bporch_end,
  parameter int v_visible    = XGA_1024x768.v_visible,
  parameter int v_fporch_end = XGA_1024x768.v_fporch_end,
  parameter int v_sync_end   = XGA_1024x768.v_sync_end,
  parameter int v_bporch_end = XGA_1024x768.v_bporch_end,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0,
  parameter int CNT_W        = 12,
  parameter int FRAME_W      = 8,
  parameter int PREFETCH     = 16,
  parameter int OUT_DELAY    = 0
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               en,
  output logic               hsync,
  output logic               vsync,
  output logic               visible_area,
  output logic [CNT_W-1:0]   hcnt,
  output logic [CNT_W-1:0]   vcnt,
  output logic               line_start,
  output logic               frame_start,
  output logic               line_prefetch,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int OW = 6 + 2 * CNT_W + FRAME_W;

  logic [CNT_W-1:0]   r_h, r_v, w_h_nxt, w_v_nxt;
  logic [FRAME_W-1:0] r_frame, w_frame_nxt;
  logic               r_started;
  logic               w_h_last, w_v_last;
  logic               w_hs_nxt, w_vs_nxt, w_vis_nxt, w_ls_nxt, w_fs_nxt, w_lp_nxt;

  logic [CNT_W-1:0]   r_hcnt, r_vcnt;
  logic               r_hs, r_vs, r_vis, r_ls, r_fs, r_lp;

  logic [OW-1:0]      w_bus, w_rst_bus, w_bus_dly;

  always_comb begin
    w_h_last = (r_h == CNT_W'(h_bporch_end - 1));
    w_v_last = (r_v == CNT_W'(v_bporch_end - 1));
    w_h_nxt  = w_h_last ? '0 : r_h + 1'b1;
    w_v_nxt  = r_v;
    if (w_h_last) w_v_nxt = w_v_last ? '0 : r_v + 1'b1;

    // The wrap out of the reset position starts frame 0; it does not complete a frame.
    w_frame_nxt = r_frame;
    if (w_h_last && w_v_last && r_started) w_frame_nxt = r_frame + 1'b1;

    w_vis_nxt = (w_h_nxt < CNT_W'(h_visible)) && (w_v_nxt < CNT_W'(v_visible));
    w_hs_nxt  = ((w_h_nxt >= CNT_W'(h_fporch_end)) && (w_h_nxt < CNT_W'(h_sync_end)))
                ? HSYNC_POL : ~HSYNC_POL;
    w_vs_nxt  = ((w_v_nxt >= CNT_W'(v_fporch_end)) && (w_v_nxt < CNT_W'(v_sync_end)))
                ? VSYNC_POL : ~VSYNC_POL;
    w_ls_nxt  = (w_h_nxt == '0);
    w_fs_nxt  = w_ls_nxt && (w_v_nxt == '0);
    w_lp_nxt  = (w_h_nxt == CNT_W'(h_bporch_end - PREFETCH)) &&
                ((w_v_nxt < CNT_W'(v_visible - 1)) || w_v_last_line(w_v_nxt));
  end

  function automatic logic w_v_last_line(input logic [CNT_W-1:0] v);
    return v == CNT_W'(v_bporch_end - 1);
  endfunction

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_h       <= CNT_W'(h_bporch_end - 1);
      r_v       <= CNT_W'(v_bporch_end - 1);
      r_frame   <= '0;
      r_started <= 1'b0;
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_hs      <= ~HSYNC_POL;
      r_vs      <= ~VSYNC_POL;
      r_vis     <= 1'b0;
      r_ls      <= 1'b0;
      r_fs      <= 1'b0;
      r_lp      <= 1'b0;
    end else if (en) begin
      r_h       <= w_h_nxt;
      r_v       <= w_v_nxt;
      r_frame   <= w_frame_nxt;
      r_started <= 1'b1;
      r_hcnt    <= w_h_nxt;
      r_vcnt    <= w_v_nxt;
      r_hs      <= w_hs_nxt;
      r_vs      <= w_vs_nxt;
      r_vis     <= w_vis_nxt;
      r_ls      <= w_ls_nxt;
      r_fs      <= w_fs_nxt;
      r_lp      <= w_lp_nxt;
    end else begin
      // Stalled: levels hold, strobes drop so nothing fires twice.
      r_ls      <= 1'b0;
      r_fs      <= 1'b0;
      r_lp      <= 1'b0;
    end
  end

  assign w_bus     = {r_hs, r_vs, r_vis, r_hcnt, r_vcnt, r_ls, r_fs, r_lp, r_frame};
  assign w_rst_bus = {~HSYNC_POL, ~VSYNC_POL, 1'b0, {CNT_W{1'b0}}, {CNT_W{1'b0}},
                      3'b000, {FRAME_W{1'b0}}};

  vga_delay_line #(
    .W     (OW),
    .DEPTH (OUT_DELAY)
  ) u_delay (
    .i_clk     (pixel_clk),
    .i_rst     (rst),
    .i_rst_val (w_rst_bus),
    .i_dat     (w_bus),
    .o_dat     (w_bus_dly)
  );

  assign {hsync, vsync, visible_area, hcnt, vcnt,
          line_start, frame_start, line_prefetch, frame_cnt} = w_bus_dly;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on the 8/10/12/14 x 4/5/6/8 test mode: base, inverted-polarity and delayed instances.
module tb_vga_timing_gen;

  localparam int HV = 8, HFP = 10, HSE = 12, HT = 14;
  localparam int VV = 4, VFP = 5, VSE = 6, VT = 8;
  localparam int PF = 3;
  localparam int FW = 2;
  localparam int CW = vga_timing_pkg::cnt_width(HT);

  typedef struct {
    bit hs, vs, vis;
    int hc, vc;
    bit ls, fs, lp;
    int fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic en;

  logic a_hs, a_vs, a_vis, a_ls, a_fs, a_lp;
  logic [CW-1:0] a_hc, a_vc;
  logic [FW-1:0] a_fc;
  logic p_hs, p_vs, p_vis, p_ls, p_fs, p_lp;
  logic [CW-1:0] p_hc, p_vc;
  logic [FW-1:0] p_fc;
  logic d_hs, d_vs, d_vis, d_ls, d_fs, d_lp;
  logic [CW-1:0] d_hc, d_vc;
  logic [FW-1:0] d_fc;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .h_visible(HV), .h_fporch_end(HFP), .h_sync_end(HSE), .h_bporch_end(HT),
    .v_visible(VV), .v_fporch_end(VFP), .v_sync_end(VSE), .v_bporch_end(VT),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(CW), .FRAME_W(FW),
    .PREFETCH(PF), .OUT_DELAY(0)
  ) u_a (
    .pixel_clk(clk), .rst(rst), .en(en),
    .hsync(a_hs), .vsync(a_vs), .visible_area(a_vis), .hcnt(a_hc), .vcnt(a_vc),
    .line_start(a_ls), .frame_start(a_fs), .line_prefetch(a_lp), .frame_cnt(a_fc)
  );

  vga_timing_gen #(
    .h_visible(HV), .h_fporch_end(HFP), .h_sync_end(HSE), .h_bporch_end(HT),
    .v_visible(VV), .v_fporch_end(VFP), .v_sync_end(VSE), .v_bporch_end(VT),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(CW), .FRAME_W(FW),
    .PREFETCH(PF), .OUT_DELAY(0)
  ) u_p (
    .pixel_clk(clk), .rst(rst), .en(en),
    .hsync(p_hs), .vsync(p_vs), .visible_area(p_vis), .hcnt(p_hc), .vcnt(p_vc),
    .line_start(p_ls), .frame_start(p_fs), .line_prefetch(p_lp), .frame_cnt(p_fc)
  );

  vga_timing_gen #(
    .h_visible(HV), .h_fporch_end(HFP), .h_sync_end(HSE), .h_bporch_end(HT),
    .v_visible(VV), .v_fporch_end(VFP), .v_sync_end(VSE), .v_bporch_end(VT),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(CW), .FRAME_W(FW),
    .PREFETCH(PF), .OUT_DELAY(2)
  ) u_d (
    .pixel_clk(clk), .rst(rst), .en(en),
    .hsync(d_hs), .vsync(d_vs), .visible_area(d_vis), .hcnt(d_hc), .vcnt(d_vc),
    .line_start(d_ls), .frame_start(d_fs), .line_prefetch(d_lp), .frame_cnt(d_fc)
  );

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs after n enabled edges since reset; adv says whether the latest edge advanced.
  function automatic exp_t model(input int n, input bit adv, input bit hp, input bit vp);
    exp_t e;
    int p, h, v;
    e.hs = ~hp; e.vs = ~vp; e.vis = 1'b0; e.hc = 0; e.vc = 0;
    e.ls = 1'b0; e.fs = 1'b0; e.lp = 1'b0; e.fc = 0;
    if (n > 0) begin
      p    = n - 1;
      h    = p % HT;
      v    = (p / HT) % VT;
      e.hc = h;
      e.vc = v;
      e.fc = (p / (HT * VT)) % (1 << FW);
      e.vis = (h < HV) && (v < VV);
      e.hs = (h >= HFP && h < HSE) ? hp : ~hp;
      e.vs = (v >= VFP && v < VSE) ? vp : ~vp;
      e.ls = adv && (h == 0);
      e.fs = e.ls && (v == 0);
      e.lp = adv && (h == HT - PF) && ((v + 1 < VV) || (v == VT - 1));
    end
    return e;
  endfunction

  task automatic chk_inst(input string t, input exp_t e, input int hs, input int vs, input int vis,
                          input int hc, input int vc, input int ls, input int fs, input int lp,
                          input int fc);
    chk({t, ".hsync"}, hs, e.hs);
    chk({t, ".vsync"}, vs, e.vs);
    chk({t, ".visible"}, vis, e.vis);
    chk({t, ".hcnt"}, hc, e.hc);
    chk({t, ".vcnt"}, vc, e.vc);
    chk({t, ".line_start"}, ls, e.ls);
    chk({t, ".frame_start"}, fs, e.fs);
    chk({t, ".line_prefetch"}, lp, e.lp);
    chk({t, ".frame_cnt"}, fc, e.fc);
  endtask

  int n = 0;
  bit adv = 1'b0;
  exp_t hist[$];

  always @(posedge clk) begin
    if (rst) begin
      n   = 0;
      adv = 1'b0;
    end else begin
      adv = en;
      if (en) n = n + 1;
    end
  end

  always @(negedge clk) begin
    exp_t ea, ep, ed;
    ea = model(rst ? 0 : n, adv, 1'b0, 1'b0);
    ep = model(rst ? 0 : n, adv, 1'b1, 1'b1);
    chk_inst("a", ea, int'(a_hs), int'(a_vs), int'(a_vis), int'(a_hc), int'(a_vc),
             int'(a_ls), int'(a_fs), int'(a_lp), int'(a_fc));
    chk_inst("p", ep, int'(p_hs), int'(p_vs), int'(p_vis), int'(p_hc), int'(p_vc),
             int'(p_ls), int'(p_fs), int'(p_lp), int'(p_fc));
    if (rst) begin
      ed   = model(0, 1'b0, 1'b0, 1'b0);
      hist = '{ed, ed};
    end else begin
      ed = hist.pop_front();
      hist.push_back(ea);
    end
    chk_inst("d", ed, int'(d_hs), int'(d_vs), int'(d_vis), int'(d_hc), int'(d_vc),
             int'(d_ls), int'(d_fs), int'(d_lp), int'(d_fc));
  end

  // Entered and left at negedge+1, so outputs are stable when checked after return.
  task automatic tick(input bit e);
    en = e;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_hcnt", int'(a_hc), 0);
    chk("rst_visible", int'(a_vis), 0);
    chk("rst_hsync", int'(a_hs), 1);
    chk("rst_vsync", int'(a_vs), 1);
    chk("rst_pol_hsync", int'(p_hs), 0);
    chk("rst_pol_vsync", int'(p_vs), 0);
    rst = 1'b0;

    tick(1'b1);
    chk("first_hcnt", int'(a_hc), 0);
    chk("first_vcnt", int'(a_vc), 0);
    chk("first_visible", int'(a_vis), 1);
    chk("first_line_start", int'(a_ls), 1);
    chk("first_frame_start", int'(a_fs), 1);
    chk("first_frame_cnt", int'(a_fc), 0);

    repeat (11) tick(1'b1);
    chk("h11_hcnt", int'(a_hc), 11);
    chk("h11_hsync", int'(a_hs), 0);
    chk("h11_prefetch", int'(a_lp), 1);
    chk("h11_pol_hsync", int'(p_hs), 1);

    repeat (3) tick(1'b1);
    chk("line1_hcnt", int'(a_hc), 0);
    chk("line1_vcnt", int'(a_vc), 1);
    chk("line1_line_start", int'(a_ls), 1);
    tick(1'b0);
    chk("stall1_hcnt", int'(a_hc), 0);
    chk("stall1_line_start", int'(a_ls), 0);
    tick(1'b0);
    chk("stall2_hcnt", int'(a_hc), 0);
    chk("stall2_line_start", int'(a_ls), 0);
    tick(1'b1);
    chk("resume_hcnt", int'(a_hc), 1);

    repeat (700) tick($urandom_range(0, 9) != 0);

    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (a_hc == CW'(5) && a_vc == CW'(2)) found = 1'b1;
      else tick(1'b1);
    end
    chk("seek_h5_v2", int'(found), 1);
    rst = 1'b1;
    #1;
    chk("midrst_hcnt", int'(a_hc), 0);
    chk("midrst_vcnt", int'(a_vc), 0);
    chk("midrst_visible", int'(a_vis), 0);
    chk("midrst_hsync", int'(a_hs), 1);
    chk("midrst_delayed_hcnt", int'(d_hc), 0);
    repeat (3) tick(1'b1);
    chk("held_rst_hcnt", int'(a_hc), 0);
    rst = 1'b0;
    tick(1'b1);
    chk("restart_hcnt", int'(a_hc), 0);
    chk("restart_vcnt", int'(a_vc), 0);
    chk("restart_frame_start", int'(a_fs), 1);
    chk("restart_frame_cnt", int'(a_fc), 0);

    repeat (240) tick(1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
